mem_req_port: RTL and testbench

Initiator-side front end for the single-read/single-write word memory (`mem`). It accepts read and write requests from a client over a valid/ready handshake and drives the memory's read-address and write ports. It tracks the memory's fixed two-cycle read latency and buffers returned read data in an in-order response FIFO with backpressure. It sits between a core/DMA client and one `mem` instance, so clients never need to count memory latency themselves.

---
 rtl/mem_req_port.sv | 131 +++++++++++++
 tb/tb_mem_req_port.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_req_port.sv
// mem_req_port
//   Initiator-side front end for the single-read/single-write word memory.
//   Accepts read/write requests over valid/ready, drives the memory read
//   address and write ports, tracks the fixed two-cycle read latency and
//   buffers returned data in an in-order response FIFO with backpressure.
//
// Parameters
//   DEPTH : response FIFO entries (3..16)
//   CW    : counter width, 2^CW > DEPTH
//
// Ports
//   clk, rst_n            : clock (rising edge), async active-low reset
//   req_valid/req_ready   : request handshake
//   req_wen               : 1 = write, 0 = read
//   req_addr, req_wdata   : word address and write data
//   rsp_valid/rsp_ready   : response handshake
//   rsp_data              : read data, in request order
//   mem_raddr, mem_rdata  : memory read port (2-cycle latency)
//   mem_wen, mem_waddr,
//   mem_wdata             : memory write port
//   busy                  : reads in flight or FIFO non-empty
module mem_req_port #(
  parameter int DEPTH = 4,
  parameter int CW    = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_wen,
  input  logic [15:1]  req_addr,
  input  logic [15:0]  req_wdata,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [15:0]  rsp_data,
  output logic [15:1]  mem_raddr,
  input  logic [15:0]  mem_rdata,
  output logic         mem_wen,
  output logic [15:1]  mem_waddr,
  output logic [15:0]  mem_wdata,
  output logic         busy
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic          v1_q, v1_d;
  logic          v2_q, v2_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [15:0]   fifo_q [DEPTH];
  logic [15:0]   fifo_d [DEPTH];

  logic [CW:0]   credit;
  logic          accept;
  logic          rd_acc;
  logic          wr_acc;
  logic          push;
  logic          pop;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) return '0;
    else                     return p + PW'(1);
  endfunction

  always_comb begin
    // Every read already accepted (in flight or buffered) holds a FIFO slot,
    // so the FIFO can never be pushed while full.
    credit    = {1'b0, count_q} + (CW+1)'(v1_q) + (CW+1)'(v2_q);
    req_ready = credit < (CW+1)'(DEPTH);

    accept    = req_valid && req_ready;
    rd_acc    = accept && !req_wen;
    wr_acc    = accept && req_wen;

    mem_raddr = req_addr;
    mem_waddr = req_addr;
    mem_wdata = req_wdata;
    mem_wen   = wr_acc;

    rsp_valid = (count_q != '0);
    rsp_data  = fifo_q[rd_ptr_q];
    busy      = v1_q | v2_q | (count_q != '0);

    // v2 marks the cycle in which mem_rdata carries the oldest in-flight read.
    push      = v2_q;
    pop       = rsp_valid && rsp_ready;
  end

  always_comb begin
    v1_d     = rd_acc;
    v2_d     = v1_q;
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (push) begin
      fifo_d[wr_ptr_q] = mem_rdata;
      wr_ptr_d         = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
    end else begin
      v1_q     <= v1_d;
      v2_q     <= v2_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      for (int i = 0; i < DEPTH; i++) fifo_q[i] <= fifo_d[i];
    end
  end

endmodule

// File: tb/tb_mem_req_port.sv
// Testbench for mem_req_port: memory environment with 2-cycle read latency,
// a reference model (word array + expected-response queue with ready cycle),
// and a negedge monitor that scores every DUT output.
module tb_mem_req_port;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [15:1] req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic [15:1] mem_raddr;
  logic [15:0] mem_rdata;
  logic        mem_wen;
  logic [15:1] mem_waddr;
  logic [15:0] mem_wdata;
  logic        busy;

  mem_req_port #(.DEPTH(DEPTH), .CW(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory environment: address sampled at the accept edge, array read one
  // edge later, data presented during the following cycle. Not reset.
  bit   [15:0] env_mem [0:32767];
  logic [15:1] env_raddr_q;
  logic [15:0] env_rdata_q;
  initial begin
    env_raddr_q = '0;
    env_rdata_q = '0;
  end
  always @(posedge clk) begin
    env_raddr_q <= mem_raddr;
    env_rdata_q <= env_mem[env_raddr_q];
    if (mem_wen) env_mem[mem_waddr] <= mem_wdata;
  end
  assign mem_rdata = env_rdata_q;

  // Reference model
  typedef struct {
    logic [15:0] data;
    int          rdy;
  } exp_t;
  bit   [15:0] ref_mem [0:32767];
  exp_t        q[$];
  int          cyc = 0;
  int          n_pass = 0;
  int          n_total = 0;
  int          n_rd_acc = 0;
  int          stalls = 0;
  int          mode = 1;   // 0: rsp_ready low, 1: high, 2: random
  logic        mon_ready;
  logic        mon_v;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h (t=%0t)", nm, got, exp, $time);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    rsp_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (mode)
        0:       rsp_ready = 1'b0;
        1:       rsp_ready = 1'b1;
        default: rsp_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  always @(negedge rst_n) q.delete();

  // Monitor: all expectations come from the queue and ref_mem.
  always @(negedge clk) begin
    if (rst_n) begin
      mon_ready = (q.size() < DEPTH);
      mon_v     = (q.size() != 0) && (q[0].rdy <= cyc);
      chk("req_ready", req_ready, mon_ready);
      chk("no_overflow", q.size() > DEPTH, 0);
      chk("busy", busy, q.size() != 0);
      chk("rsp_valid", rsp_valid, mon_v);
      if (rsp_valid && mon_v) chk("rsp_data", rsp_data, q[0].data);
      chk("mem_wen", mem_wen, req_valid && mon_ready && req_wen);
      if (req_valid && req_ready) begin
        if (req_wen) begin
          chk("mem_waddr", mem_waddr, req_addr);
          chk("mem_wdata", mem_wdata, req_wdata);
          ref_mem[req_addr] = req_wdata;
        end else begin
          chk("mem_raddr", mem_raddr, req_addr);
          q.push_back('{data: ref_mem[req_addr], rdy: cyc + 3});
          n_rd_acc++;
        end
      end
      if (rsp_valid && rsp_ready && q.size() != 0) void'(q.pop_front());
    end
  end

  task automatic do_req(input bit wen, input logic [15:1] addr, input logic [15:0] data);
    bit ok;
    ok        = 1'b0;
    req_valid = 1'b1;
    req_wen   = wen;
    req_addr  = addr;
    req_wdata = data;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (req_ready) begin
        ok = 1'b1;
        break;
      end
      stalls++;
    end
    if (!ok) chk("req_timeout", 0, 1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (q.size() == 0) break;
    end
    @(negedge clk);
    chk("drain", q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    req_valid = 1'b0;
    req_wen   = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    rst_n     = 1'b1;

    // Reset values
    #3 rst_n = 1'b0;
    #1;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mem_wen", mem_wen, 0);
    chk("rst_rsp_data", rsp_data, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Write then read, directed latency
    do_req(1'b1, 15'h0010, 16'hBEEF);
    do_req(1'b0, 15'h0010, 16'h0);
    @(negedge clk); chk("wr_rd_lat1", rsp_valid, 0);
    @(negedge clk); chk("wr_rd_lat2", rsp_valid, 0);
    @(negedge clk); chk("wr_rd_valid", rsp_valid, 1);
    chk("wr_rd_data", rsp_data, 16'hBEEF);
    @(negedge clk); chk("wr_rd_busy_fall", busy, 0);
    drain();

    // Streaming
    for (int a = 0; a < 8; a++) do_req(1'b1, 15'(a), 16'(16'h1000 + a));
    stalls = 0;
    for (int a = 0; a < 8; a++) do_req(1'b0, 15'(a), 16'h0);
    chk("stream_no_stall", stalls, 0);
    drain();

    // Backpressure
    mode = 0;
    repeat (2) @(posedge clk);
    #1;
    base   = n_rd_acc;
    stalls = 0;
    for (int a = 0; a < 4; a++) do_req(1'b0, 15'(a), 16'h0);
    chk("bp_first4_no_stall", stalls, 0);
    req_valid = 1'b1; req_wen = 1'b0; req_addr = 15'd4;
    repeat (3) begin
      @(negedge clk);
      chk("bp_read_stalled", req_ready, 0);
    end
    chk("bp_accepted", n_rd_acc - base, 4);
    req_wen = 1'b1; req_wdata = 16'hDEAD;
    repeat (2) begin
      @(negedge clk);
      chk("bp_write_stalled", mem_wen, 0);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    mode = 1;
    do_req(1'b0, 15'd4, 16'h0);
    do_req(1'b0, 15'd5, 16'h0);
    drain();
    chk("bp_ready_back", req_ready, 1);

    // Read then write same address
    do_req(1'b1, 15'h0020, 16'h1111);
    do_req(1'b0, 15'h0020, 16'h0);
    do_req(1'b1, 15'h0020, 16'h2222);
    do_req(1'b0, 15'h0020, 16'h0);
    drain();

    // FIFO wrap with random backpressure and interleaved writes
    mode = 2;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 99) < 30)
        do_req(1'b1, 15'($urandom_range(0, 15)), 16'($urandom));
      do_req(1'b0, 15'($urandom_range(0, 15)), 16'h0);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end
    mode = 1;
    drain();

    // Reset mid-operation: 2 reads in flight, 2 in the FIFO
    mode = 0;
    repeat (2) @(posedge clk);
    #1;
    for (int a = 0; a < 4; a++) do_req(1'b0, 15'(a), 16'h0);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_req_ready", req_ready, 1);
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_mem_wen", mem_wen, 0);
    chk("mid_rst_rsp_data", rsp_data, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    mode = 1;
    repeat (6) @(posedge clk);
    #1;
    do_req(1'b0, 15'h0010, 16'h0);
    drain();

    chk("final_empty", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
